// File: rtl/axis_extremum_scheduler_if.sv
// AXI-Stream slave bundle carrying the packed two-channel ADC word.
// The consumer ties tready high, so the stream is never back-pressured.
interface axis_extremum_scheduler_if #(
   parameter int AXIS_TDATA_WIDTH = 32
) ();
   logic                        tvalid;
   logic [AXIS_TDATA_WIDTH-1:0] tdata;
   logic                        tready;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_extremum_scheduler.sv
// Round-robin min/max threshold scheduler for two signed channels packed in one AXI-Stream word.
// Optional per-channel commit counters are built when AXIS_EXTREMUM_SCHEDULER_STATS_EN is defined.
module axis_extremum_scheduler #(
   parameter int  AXIS_TDATA_WIDTH = 32,
   localparam int W                = AXIS_TDATA_WIDTH / 2
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [4:0]           cfg_log_count,
   input  logic [2:0]           cfg_shift,
   input  logic [1:0]           cfg_channel_mask,
   axis_extremum_scheduler_if.slave s_axis,
   output logic [W-1:0]         lower_threshold_a,
   output logic [W-1:0]         upper_threshold_a,
   output logic [W-1:0]         lower_threshold_b,
   output logic [W-1:0]         upper_threshold_b,
   output logic [1:0]           thresholds_valid,
   output logic                 active_channel,
   output logic                 window_done
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
  ,output logic [15:0]          commit_count_a,
   output logic [15:0]          commit_count_b
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;
   localparam logic [1:0] ST_COMMIT  = 2'd3;

   localparam logic signed [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

   logic [1:0]          state;
   logic [4:0]          log_count_q;
   logic [2:0]          shift_q;
   logic                last_b;
   logic signed [W-1:0] tmp_min;
   logic signed [W-1:0] tmp_max;
   logic [31:0]         beat_count;

   logic signed [W-1:0] sample;
   logic [31:0]         terminal;
   logic                next_channel;
   logic signed [W:0]   min_ext;
   logic signed [W:0]   max_ext;
   logic signed [W:0]   center;
   logic signed [W:0]   lo_diff;
   logic signed [W:0]   hi_diff;
   logic signed [W:0]   lo_wide;
   logic signed [W:0]   hi_wide;

   assign s_axis.tready = 1'b1;

   // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      sample   = active_channel ? $signed(s_axis.tdata[2*W-1:W]) : $signed(s_axis.tdata[W-1:0]);
      terminal = (32'd1 << log_count_q) - 32'd1;
      // Two enabled channels alternate; a single enabled channel wins every window.
      next_channel = (cfg_channel_mask == 2'b11) ? ~last_b : cfg_channel_mask[1];
      // One guard bit keeps the midpoint and the half-spans from overflowing.
      min_ext = {tmp_min[W-1], tmp_min};
      max_ext = {tmp_max[W-1], tmp_max};
      center  = (max_ext + min_ext) >>> 1;
      lo_diff = min_ext - center;
      hi_diff = max_ext - center;
      lo_wide = (lo_diff >>> shift_q) + center;
      hi_wide = (hi_diff >>> shift_q) + center;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state             <= ST_IDLE;
         log_count_q       <= '0;
         shift_q           <= '0;
         last_b            <= 1'b1;
         tmp_min           <= POS_MAX;
         tmp_max           <= NEG_MAX;
         beat_count        <= '0;
         lower_threshold_a <= POS_MAX;
         upper_threshold_a <= NEG_MAX;
         lower_threshold_b <= POS_MAX;
         upper_threshold_b <= NEG_MAX;
         thresholds_valid  <= '0;
         active_channel    <= 1'b0;
         window_done       <= 1'b0;
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
         commit_count_a    <= '0;
         commit_count_b    <= '0;
`endif
      end else begin
         window_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_channel_mask != 2'b00) state <= ST_ARM;
            end
            ST_ARM: begin
               log_count_q <= cfg_log_count;
               shift_q     <= cfg_shift;
               if (cfg_channel_mask == 2'b00) begin
                  state <= ST_IDLE;
               end else begin
                  active_channel <= next_channel;
                  last_b         <= next_channel;
                  tmp_min        <= POS_MAX;
                  tmp_max        <= NEG_MAX;
                  beat_count     <= '0;
                  state          <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (s_axis.tvalid) begin
                  if (sample < tmp_min) tmp_min <= sample;
                  if (sample > tmp_max) tmp_max <= sample;
                  beat_count <= beat_count + 32'd1;
                  if (beat_count == terminal) state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (active_channel) begin
                  lower_threshold_b <= lo_wide[W-1:0];
                  upper_threshold_b <= hi_wide[W-1:0];
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
                  commit_count_b    <= commit_count_b + 16'd1;
`endif
               end else begin
                  lower_threshold_a <= lo_wide[W-1:0];
                  upper_threshold_a <= hi_wide[W-1:0];
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
                  commit_count_a    <= commit_count_a + 16'd1;
`endif
               end
               thresholds_valid[active_channel] <= 1'b1;
               window_done                      <= 1'b1;
               state                            <= ST_ARM;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_extremum_scheduler.sv
// Self-checking bench: a window-level reference model compared against the scheduler every cycle,
// plus directed scenarios pinned with hand-computed values.
module tb_axis_extremum_scheduler;
   localparam int W = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [4:0]    cfg_log_count = '0;
   logic [2:0]    cfg_shift = '0;
   logic [1:0]    cfg_channel_mask = '0;
   logic [W-1:0]  lower_threshold_a, upper_threshold_a;
   logic [W-1:0]  lower_threshold_b, upper_threshold_b;
   logic [1:0]    thresholds_valid;
   logic          active_channel;
   logic          window_done;
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
   logic [15:0]   commit_count_a, commit_count_b;
`endif

   axis_extremum_scheduler_if #(.AXIS_TDATA_WIDTH(32)) s_axis ();

   axis_extremum_scheduler #(.AXIS_TDATA_WIDTH(32)) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .cfg_log_count     (cfg_log_count),
      .cfg_shift         (cfg_shift),
      .cfg_channel_mask  (cfg_channel_mask),
      .s_axis            (s_axis),
      .lower_threshold_a (lower_threshold_a),
      .upper_threshold_a (upper_threshold_a),
      .lower_threshold_b (lower_threshold_b),
      .upper_threshold_b (upper_threshold_b),
      .thresholds_valid  (thresholds_valid),
      .active_channel    (active_channel),
      .window_done       (window_done)
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
     ,.commit_count_a    (commit_count_a),
      .commit_count_b    (commit_count_b)
`endif
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_pass   = 0;
   bit rand_data = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model: collects a window's beats, evaluates it at commit -------------
   typedef enum int {P_IDLE, P_ARM, P_MEAS, P_COMMIT} phase_t;
   phase_t       mphase = P_IDLE;
   int           beats[$];
   bit           m_next_b = 1'b0;
   bit           m_ch = 1'b0;
   int           m_log = 0;
   int           m_shift = 0;
   logic [W-1:0] exp_lo_a = 16'h7fff, exp_hi_a = 16'h8000;
   logic [W-1:0] exp_lo_b = 16'h7fff, exp_hi_b = 16'h8000;
   logic [1:0]   exp_valid = 2'b00;
   logic         exp_active = 1'b0;
   logic         exp_done = 1'b0;
   logic [15:0]  exp_cnt_a = '0, exp_cnt_b = '0;

   function automatic int half(input logic [31:0] d, input bit ch);
      logic signed [15:0] h;
      h = ch ? d[31:16] : d[15:0];
      return int'(h);
   endfunction

   task automatic model_commit();
      int mn, mx, c, lo, hi;
      mn = beats[0];
      mx = beats[0];
      foreach (beats[i]) begin
         if (beats[i] < mn) mn = beats[i];
         if (beats[i] > mx) mx = beats[i];
      end
      c  = (mx + mn) >>> 1;
      lo = ((mn - c) >>> m_shift) + c;
      hi = ((mx - c) >>> m_shift) + c;
      if (m_ch) begin
         exp_lo_b  = lo[15:0];
         exp_hi_b  = hi[15:0];
         exp_cnt_b = exp_cnt_b + 16'd1;
      end else begin
         exp_lo_a  = lo[15:0];
         exp_hi_a  = hi[15:0];
         exp_cnt_a = exp_cnt_a + 16'd1;
      end
      exp_valid[m_ch] = 1'b1;
      exp_done = 1'b1;
   endtask

   always @(posedge aclk) begin
      if (!aresetn) begin
         mphase = P_IDLE;
         m_next_b = 1'b0;
         beats.delete();
         exp_lo_a = 16'h7fff; exp_hi_a = 16'h8000;
         exp_lo_b = 16'h7fff; exp_hi_b = 16'h8000;
         exp_valid = 2'b00; exp_active = 1'b0; exp_done = 1'b0;
         exp_cnt_a = '0; exp_cnt_b = '0;
      end else begin
         exp_done = 1'b0;
         case (mphase)
            P_IDLE: if (cfg_channel_mask != 2'b00) mphase = P_ARM;
            P_ARM: begin
               m_log   = int'(cfg_log_count);
               m_shift = int'(cfg_shift);
               if (cfg_channel_mask == 2'b00) mphase = P_IDLE;
               else begin
                  m_ch = (cfg_channel_mask == 2'b11) ? m_next_b : cfg_channel_mask[1];
                  m_next_b = !m_ch;
                  exp_active = m_ch;
                  beats.delete();
                  mphase = P_MEAS;
               end
            end
            P_MEAS: if (s_axis.tvalid) begin
               beats.push_back(half(s_axis.tdata, m_ch));
               if (beats.size() == (1 << m_log)) mphase = P_COMMIT;
            end
            P_COMMIT: begin
               model_commit();
               mphase = P_ARM;
            end
            default: mphase = P_IDLE;
         endcase
      end
   end

   // Per-cycle comparison away from the active edge.
   initial begin
      @(posedge aclk);
      forever begin
         @(negedge aclk);
         check("thr_a", 64'({lower_threshold_a, upper_threshold_a}), 64'({exp_lo_a, exp_hi_a}));
         check("thr_b", 64'({lower_threshold_b, upper_threshold_b}), 64'({exp_lo_b, exp_hi_b}));
         check("flags", 64'({thresholds_valid, active_channel, window_done}),
               64'({exp_valid, exp_active, exp_done}));
`ifdef AXIS_EXTREMUM_SCHEDULER_STATS_EN
         check("counts", 64'({commit_count_a, commit_count_b}), 64'({exp_cnt_a, exp_cnt_b}));
`endif
      end
   end

   // ---------------- stimulus helpers ---------------------------------------------------------------
   task automatic tick();
      @(posedge aclk);
      #1;
      if (rand_data) s_axis.tdata = $urandom;
   endtask

   task automatic wait_meas(input string name);
      int n = 0;
      while (mphase != P_MEAS && n < 100) begin
         tick();
         n++;
      end
      check({name, "_meas_wait"}, 64'(n < 100), 64'd1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (window_done !== 1'b1 && n < 200);
      check({name, "_done_wait"}, 64'(n < 200), 64'd1);
   endtask

   task automatic send_a(input int v);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = {16'($urandom), 16'(v)};
      tick();
      s_axis.tvalid = 1'b0;
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_lo_a"}, 64'(lower_threshold_a), 64'h7fff);
      check({name, "_hi_a"}, 64'(upper_threshold_a), 64'h8000);
      check({name, "_lo_b"}, 64'(lower_threshold_b), 64'h7fff);
      check({name, "_hi_b"}, 64'(upper_threshold_b), 64'h8000);
      check({name, "_flags"}, 64'({thresholds_valid, active_channel, window_done}), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic a1;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;

      // Reset state
      repeat (3) tick();
      check_reset_values("reset");

      // Single-channel window: 100, -50, 20, 0 with shift 1 gives -13 / 62
      cfg_channel_mask = 2'b01; cfg_log_count = 5'd2; cfg_shift = 3'd1;
      aresetn = 1'b1;
      wait_meas("basic");
      send_a(100); send_a(-50); send_a(20); send_a(0);
      wait_done("basic");
      check("basic_lo_a", 64'(lower_threshold_a), 64'hfff3);
      check("basic_hi_a", 64'(upper_threshold_a), 64'd62);
      check("basic_valid", 64'(thresholds_valid), 64'b01);
      check("basic_lo_b", 64'(lower_threshold_b), 64'h7fff);

      // Both channels, 2-beat windows, continuous valid
      cfg_channel_mask = 2'b11; cfg_log_count = 5'd1; cfg_shift = 3'd0;
      rand_data = 1'b1;
      s_axis.tvalid = 1'b1;
      wait_done("rr_first");
      wait_done("rr_second");
      a1 = active_channel;
      n = 0;
      do begin
         tick();
         n++;
      end while (window_done !== 1'b1 && n < 50);
      check("rr_period", 64'(n), 64'd4);
      check("rr_alternate", 64'(active_channel), 64'(!a1));
      repeat (20) tick();

      // tvalid toggling with 8-beat windows
      cfg_log_count = 5'd3;
      for (int i = 0; i < 80; i++) begin
         s_axis.tvalid = i[0];
         tick();
      end
      s_axis.tvalid = 1'b0;
      rand_data = 1'b0;

      // Full-scale extremes cannot overflow the midpoint
      aresetn = 1'b0;
      cfg_channel_mask = 2'b01; cfg_log_count = 5'd1; cfg_shift = 3'd0;
      repeat (2) tick();
      aresetn = 1'b1;
      wait_meas("ext");
      send_a(-32768); send_a(32767);
      wait_done("ext");
      check("ext_lo_a", 64'(lower_threshold_a), 64'h8000);
      check("ext_hi_a", 64'(upper_threshold_a), 64'h7fff);

      // Shift change mid-window applies to the following window only
      cfg_log_count = 5'd2; cfg_shift = 3'd1;
      wait_meas("shift");
      send_a(100); send_a(-50);
      cfg_shift = 3'd3;
      send_a(20); send_a(0);
      wait_done("shift_old");
      check("shift_old_lo", 64'(lower_threshold_a), 64'hfff3);
      check("shift_old_hi", 64'(upper_threshold_a), 64'd62);
      wait_meas("shift_new");
      send_a(100);
      cfg_channel_mask = 2'b00;
      send_a(-50); send_a(20); send_a(0);
      wait_done("shift_new");
      check("shift_new_lo", 64'(lower_threshold_a), 64'd15);
      check("shift_new_hi", 64'(upper_threshold_a), 64'd34);
      rand_data = 1'b1;
      s_axis.tvalid = 1'b1;
      repeat (12) tick();
      check("idle_done", 64'(window_done), 64'd0);
      check("idle_hold_lo", 64'(lower_threshold_a), 64'd15);
      check("idle_hold_valid", 64'(thresholds_valid), 64'b01);

      // Reset mid-window discards the partial result; A is scheduled first afterwards
      cfg_channel_mask = 2'b11; cfg_log_count = 5'd2; cfg_shift = 3'd0;
      repeat (4) tick();
      aresetn = 1'b0;
      repeat (2) tick();
      check_reset_values("midrst");
      aresetn = 1'b1;
      wait_done("post_rst");
      check("post_rst_active", 64'(active_channel), 64'd0);
      check("post_rst_valid", 64'(thresholds_valid), 64'b01);

      // Randomized traffic, configuration churn and occasional resets
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            cfg_channel_mask = 2'($urandom);
            cfg_log_count    = 5'($urandom_range(0, 4));
            cfg_shift        = 3'($urandom);
         end
         s_axis.tvalid = ($urandom_range(0, 3) != 0);
         aresetn = ($urandom_range(0, 199) != 0);
         tick();
      end
      aresetn = 1'b1;
      s_axis.tvalid = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
